mutative_plru: RTL and testbench

Per-set tree pseudo-LRU replacement unit for the mutative cache, sitting directly downstream of the mutative comparator. It consumes the comparator's hit indication and hit way to track recency, and supplies the cache controller with a victim way on a miss. Victim choice is restricted to the way group selected by the current associativity setup (direct-mapped, 2-, 4- or 8-way). The unit holds one 7-bit tree per set in flops and clears all trees when the setup changes.

---
 rtl/mutative_plru.sv | 111 +++++++++++
 tb/tb_mutative_plru.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mutative_plru.sv
// mutative_plru: per-set 7-bit tree pseudo-LRU for the mutative cache.
// It tracks recency from hits and fills. On request it returns a victim way
// from the way group that the associativity setup selects.
module mutative_plru #(
  parameter int unsigned SETS         = 16,
  parameter int unsigned SET_IDX_BITS = $clog2(SETS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              setup,
  input  logic [SET_IDX_BITS-1:0] set_idx,
  input  logic [2:0]              tag_low,
  input  logic                    hit_valid,
  input  logic [2:0]              hit_way,
  input  logic                    fill_valid,
  input  logic [2:0]              fill_way,
  input  logic                    victim_req,
  output logic                    victim_valid,
  output logic [2:0]              victim_way
);

  typedef enum logic [1:0] {
    MODE_DM = 2'd0,
    MODE_2W = 2'd1,
    MODE_4W = 2'd2,
    MODE_8W = 2'd3
  } mode_e;

  logic [6:0] tree_q [SETS];
  mode_e      setup_q;
  mode_e      mode;
  logic       setup_chg;
  logic [6:0] tree_cur;
  logic [6:0] tree_d;
  logic [2:0] touch_way;
  logic [2:0] victim_d;
  logic       victim_valid_d;
  logic [2:0] victim_way_d;

  // Points every node on the path to w away from w. Only the levels that the
  // current mode uses are updated.
  function automatic logic [6:0] touch(input logic [6:0] t, input mode_e m,
                                       input logic [2:0] w);
    logic [6:0] r;
    r = t;
    if (m == MODE_8W)
      r[0] = ~w[2];
    if (m == MODE_8W || m == MODE_4W)
      r[3'd1 + {2'b00, w[2]}] = ~w[1];
    if (m != MODE_DM)
      r[3'd3 + {1'b0, w[2:1]}] = ~w[0];
    return r;
  endfunction

  // Walks the tree from the root of the group selected by tag_low. Bits above
  // the start level come from the tag, and the rest come from the node bits.
  function automatic logic [2:0] walk(input logic [6:0] t, input mode_e m,
                                      input logic [2:0] tag);
    logic [2:0] v;
    v = tag;
    case (m)
      MODE_8W: begin
        v[2] = t[0];
        v[1] = t[3'd1 + {2'b00, v[2]}];
        v[0] = t[3'd3 + {1'b0, v[2:1]}];
      end
      MODE_4W: begin
        v[1] = t[3'd1 + {2'b00, v[2]}];
        v[0] = t[3'd3 + {1'b0, v[2:1]}];
      end
      MODE_2W: v[0] = t[3'd3 + {1'b0, v[2:1]}];
      MODE_DM: v = tag;
    endcase
    return v;
  endfunction

  assign mode      = mode_e'(setup);
  assign setup_chg = (mode != setup_q);
  assign tree_cur  = tree_q[set_idx];

  // Next tree for the addressed set and the victim from the pre-update state.
  // On a setup change, the victim output stays invalid and victim_way keeps
  // its last value.
  always_comb begin
    touch_way      = fill_valid ? fill_way : hit_way;
    tree_d         = touch(tree_cur, mode, touch_way);
    victim_d       = walk(tree_cur, mode, tag_low);
    victim_valid_d = victim_req && !setup_chg;
    victim_way_d   = victim_valid_d ? victim_d : victim_way;
  end

  // Tree storage, setup history and registered victim output.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < SETS; i++) tree_q[i] <= '0;
      setup_q      <= MODE_DM;
      victim_valid <= 1'b0;
      victim_way   <= '0;
    end else begin
      setup_q      <= mode;
      victim_valid <= victim_valid_d;
      victim_way   <= victim_way_d;
      if (setup_chg) begin
        for (int unsigned i = 0; i < SETS; i++) tree_q[i] <= '0;
      end else if (fill_valid || hit_valid) begin
        tree_q[set_idx] <= tree_d;
      end
    end
  end

endmodule

// File: tb/tb_mutative_plru.sv
// Bench for mutative_plru: a level/node-index reference model is compared
// against the outputs every cycle. Directed literal cases and random traffic
// are also applied.
module tb_mutative_plru;

  localparam int NSETS = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] setup = 2'd0;
  logic [3:0] set_idx = 4'd0;
  logic [2:0] tag_low = 3'd0;
  logic       hit_valid = 1'b0;
  logic [2:0] hit_way = 3'd0;
  logic       fill_valid = 1'b0;
  logic [2:0] fill_way = 3'd0;
  logic       victim_req = 1'b0;
  logic       victim_valid;
  logic [2:0] victim_way;

  int errors = 0;
  int checks = 0;

  mutative_plru #(.SETS(NSETS)) dut (
    .clk(clk), .rst(rst), .setup(setup), .set_idx(set_idx), .tag_low(tag_low),
    .hit_valid(hit_valid), .hit_way(hit_way), .fill_valid(fill_valid),
    .fill_way(fill_way), .victim_req(victim_req), .victim_valid(victim_valid),
    .victim_way(victim_way)
  );

  always #5 clk = ~clk;

  // Reference state: heap-numbered node bits, where depth d node k = 2^d-1+k.
  bit mt [NSETS][7];
  int m_setup_q = 0;
  bit exp_valid = 0;
  int exp_way = 0;
  bit model_live = 0;

  function automatic void m_clear();
    for (int s = 0; s < NSETS; s++)
      for (int n = 0; n < 7; n++) mt[s][n] = 0;
  endfunction

  // Mode m uses the lowest m levels of the tree, so updates start at depth 3-m.
  function automatic void m_touch(int s, int m, int w);
    for (int d = 3 - m; d < 3; d++) begin
      int node;
      node = (1 << d) - 1 + (w >> (3 - d));
      mt[s][node] = (((w >> (2 - d)) & 1) == 0);
    end
  endfunction

  function automatic int m_victim(int s, int m, int tag);
    int v;
    v = tag >> m;
    for (int d = 3 - m; d < 3; d++) begin
      int node;
      node = (1 << d) - 1 + v;
      v = (v << 1) | int'(mt[s][node]);
    end
    return v;
  endfunction

  // Model advances on each clock edge with the same inputs as the DUT.
  always @(posedge clk) begin
    if (rst) begin
      m_clear();
      m_setup_q = 0;
      exp_valid = 0;
      exp_way   = 0;
    end else if (int'(setup) != m_setup_q) begin
      m_clear();
      m_setup_q = int'(setup);
      exp_valid = 0;
    end else begin
      exp_valid = victim_req;
      if (victim_req) exp_way = m_victim(int'(set_idx), int'(setup), int'(tag_low));
      if (fill_valid) m_touch(int'(set_idx), int'(setup), int'(fill_way));
      else if (hit_valid) m_touch(int'(set_idx), int'(setup), int'(hit_way));
    end
    model_live = 1;
  end

  // Every-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin
    if (model_live) begin
      checks++;
      if (victim_valid !== exp_valid) begin
        errors++;
        $display("FAIL victim_valid @%0t: got %0b expected %0b", $time, victim_valid, exp_valid);
      end
      checks++;
      if (victim_way !== 3'(exp_way)) begin
        errors++;
        $display("FAIL victim_way @%0t: got %0d expected %0d", $time, victim_way, exp_way);
      end
    end
  end

  task automatic step(input logic r, input logic [1:0] su, input logic [3:0] si,
                      input logic [2:0] tl, input logic hv, input logic [2:0] hw,
                      input logic fv, input logic [2:0] fw, input logic vr);
    rst = r; setup = su; set_idx = si; tag_low = tl;
    hit_valid = hv; hit_way = hw; fill_valid = fv; fill_way = fw; victim_req = vr;
    @(negedge clk);
  endtask

  task automatic lit(input string name, input logic ev, input logic [2:0] ew);
    checks++;
    if (victim_valid !== ev || (ev && victim_way !== ew)) begin
      errors++;
      $display("FAIL %s: got valid=%0b way=%0d, expected valid=%0b way=%0d",
               name, victim_valid, victim_way, ev, ew);
    end
  endtask

  task automatic req(input string name, input logic [1:0] su, input logic [3:0] si,
                     input logic [2:0] tl, input logic [2:0] ew);
    step(0, su, si, tl, 0, 0, 0, 0, 1);
    lit(name, 1'b1, ew);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    lit("reset", 1'b0, 3'd0);

    // 8-way on set 0
    step(0, 3, 0, 0, 0, 0, 0, 0, 0);
    req("8w_init", 3, 0, 0, 3'd0);
    step(0, 3, 0, 0, 1, 0, 0, 0, 0);
    req("8w_hit0", 3, 0, 0, 3'd4);
    step(0, 3, 0, 0, 1, 4, 0, 0, 0);
    req("8w_hit4", 3, 0, 0, 3'd2);

    // 4-way on upper quad
    step(0, 2, 0, 0, 0, 0, 0, 0, 0);
    req("4w_init", 2, 2, 3'b100, 3'd4);
    step(0, 2, 2, 3'b100, 1, 4, 0, 0, 0);
    req("4w_hit4", 2, 2, 3'b100, 3'd6);
    req("4w_set3", 2, 3, 3'b100, 3'd4);

    // 2-way and DM
    step(0, 1, 0, 0, 0, 0, 0, 0, 0);
    req("2w_init", 1, 5, 3'b010, 3'd2);
    step(0, 1, 5, 3'b010, 1, 2, 0, 0, 0);
    req("2w_hit2", 1, 5, 3'b010, 3'd3);
    step(0, 0, 5, 5, 0, 0, 0, 0, 0);
    step(0, 0, 5, 5, 1, 3, 0, 0, 0);
    req("dm_tag5", 0, 5, 5, 3'd5);

    // read-before-write and fill priority on set 1
    step(0, 3, 1, 0, 0, 0, 0, 0, 0);
    step(0, 3, 1, 0, 1, 0, 0, 0, 1);
    lit("rbw_old", 1'b1, 3'd0);
    req("rbw_new", 3, 1, 0, 3'd4);
    step(0, 3, 1, 0, 1, 0, 1, 4, 0);
    req("fill_prio", 3, 1, 0, 3'd2);

    // setup change clears trees and drops a same-cycle request
    step(0, 3, 7, 0, 1, 0, 0, 0, 0);
    step(0, 1, 7, 0, 0, 0, 0, 0, 1);
    lit("chg_drop", 1'b0, 3'd0);
    step(0, 3, 7, 0, 0, 0, 0, 0, 0);
    req("chg_clear", 3, 7, 0, 3'd0);

    // reset with a request in flight
    step(0, 3, 0, 0, 1, 0, 0, 0, 0);
    step(1, 3, 0, 0, 0, 0, 0, 0, 1);
    lit("rst_drop", 1'b0, 3'd0);
    step(0, 3, 0, 0, 0, 0, 0, 0, 0);
    req("rst_clear", 3, 0, 0, 3'd0);

    // random traffic on a few sets with occasional setup changes and resets
    for (int i = 0; i < 3000; i++) begin
      logic [1:0] su;
      su = ($urandom_range(0, 59) == 0) ? 2'($urandom_range(0, 3)) : setup;
      step(($urandom_range(0, 299) == 0), su, 4'($urandom_range(0, 3) * 5),
           3'($urandom), ($urandom_range(0, 9) < 4), 3'($urandom),
           ($urandom_range(0, 9) < 2), 3'($urandom), ($urandom_range(0, 1) == 1));
    end

    step(0, setup, 0, 0, 0, 0, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
